// File: rtl/temp_sample_sched.sv
`default_nettype none
// ============================================================================
// temp_sample_sched : periodic DS18B20 sampling scheduler with retry/timeout,
//                     fixed-point split and hysteretic over-temperature alarm.
//                     Optional 4-sample averaging when TEMP_AVG_EN is defined.
// Revision: 1.0
// ============================================================================
module temp_sample_sched #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int PERIOD_MS   = 1000,
  parameter int TIMEOUT_MS  = 1500,
  parameter int MAX_RETRY   = 3,
  parameter int HYST        = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        enable,
  input  logic        force_req,
  output logic        conv_start,
  input  logic        sensor_done,
  input  logic        sensor_ok,
  input  logic [15:0] sensor_temp,
  input  logic [7:0]  alarm_th,
  output logic [15:0] temp_raw,
  output logic [7:0]  temp_int,
  output logic [3:0]  temp_deci,
  output logic        temp_valid,
  output logic        alarm,
  output logic        fault,
  output logic        busy
);

  localparam int TICK_DIV = (CLK_FREQ_HZ / 1000 < 1) ? 1 : CLK_FREQ_HZ / 1000;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MS_MAX   = (PERIOD_MS > TIMEOUT_MS) ? PERIOD_MS : TIMEOUT_MS;
  localparam int CW       = $clog2(MS_MAX + 1);
  localparam int RW       = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_EVAL  = 3'd3,
    S_GAP   = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q;
  logic          tick;
  logic [CW-1:0] ms_q, ms_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          fault_q, fault_d;
  logic          samp_ok_q, samp_ok_d;
  logic [15:0]   samp_temp_q, samp_temp_d;
  logic          pend_q, pend_d;
  logic [15:0]   pend_raw_q, pend_raw_d;
  logic [15:0]   new_raw;
  logic          attempt_fail;

  logic [15:0]   temp_raw_q;
  logic [7:0]    temp_int_q;
  logic [3:0]    temp_deci_q;
  logic          valid_q;
  logic          alarm_q, alarm_d;
  logic [3:0]    deci_w;
  logic signed [9:0] int_s, th_s, rel_s;

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ms_d         = ms_q;
    retry_d      = retry_q;
    fault_d      = fault_q;
    samp_ok_d    = samp_ok_q;
    samp_temp_d  = samp_temp_q;
    pend_d       = 1'b0;
    pend_raw_d   = pend_raw_q;
    attempt_fail = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (force_req) begin
          state_d = S_REQ;
        end else if (tick) begin
          if (enable && (ms_q == CW'(PERIOD_MS - 1))) begin
            state_d = S_REQ;
          end else if (ms_q != CW'(PERIOD_MS - 1)) begin
            ms_d = ms_q + CW'(1);
          end
        end
      end
      S_REQ: begin
        ms_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion in the timeout cycle still counts as a completion.
        if (sensor_done) begin
          samp_ok_d   = sensor_ok;
          samp_temp_d = sensor_temp;
          state_d     = S_EVAL;
        end else if (tick) begin
          if (ms_q == CW'(TIMEOUT_MS - 1)) begin
            attempt_fail = 1'b1;
          end else begin
            ms_d = ms_q + CW'(1);
          end
        end
      end
      S_EVAL: begin
        if (samp_ok_q) begin
          pend_d     = 1'b1;
          pend_raw_d = new_raw;
          retry_d    = '0;
          fault_d    = 1'b0;
          ms_d       = '0;
          state_d    = S_IDLE;
        end else begin
          attempt_fail = 1'b1;
        end
      end
      S_GAP: begin
        if (tick) begin
          state_d = S_REQ;
        end
      end
      S_FAULT: begin
        if (force_req) begin
          fault_d = 1'b0;
          retry_d = '0;
          state_d = S_REQ;
        end else if (!enable) begin
          fault_d = 1'b0;
          retry_d = '0;
          ms_d    = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (attempt_fail) begin
      retry_d = retry_q + RW'(1);
      if (retry_q + RW'(1) == RW'(MAX_RETRY)) begin
        fault_d = 1'b1;
        state_d = S_FAULT;
      end else begin
        state_d = S_GAP;
      end
    end
  end

`ifdef TEMP_AVG_EN
  logic [15:0]       hist_q [4];
  logic [15:0]       hist_d [4];
  logic              primed_q;
  logic signed [17:0] sum_w;

  // The first good sample after reset fills the whole window so the average starts settled.
  always_comb begin
    if (primed_q) begin
      hist_d[0] = samp_temp_q;
      hist_d[1] = hist_q[0];
      hist_d[2] = hist_q[1];
      hist_d[3] = hist_q[2];
    end else begin
      for (int i = 0; i < 4; i++) hist_d[i] = samp_temp_q;
    end
    sum_w = '0;
    for (int i = 0; i < 4; i++) sum_w = sum_w + $signed({{2{hist_d[i][15]}}, hist_d[i]});
    new_raw = sum_w[17:2];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hist_q   <= '{default: '0};
      primed_q <= 1'b0;
    end else if (state_q == S_EVAL && samp_ok_q) begin
      hist_q   <= hist_d;
      primed_q <= 1'b1;
    end
  end
`else
  assign new_raw = samp_temp_q;
`endif

  assign deci_w = 4'(({4'b0, pend_raw_q[3:0]} * 8'd10) >> 4);
  assign int_s  = $signed({{2{pend_raw_q[11]}}, pend_raw_q[11:4]});
  assign th_s   = $signed({{2{alarm_th[7]}}, alarm_th});
  assign rel_s  = th_s - 10'(HYST);

  always_comb begin
    alarm_d = alarm_q;
    if (int_s >= th_s) begin
      alarm_d = 1'b1;
    end else if (int_s < rel_s) begin
      alarm_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      presc_q     <= '0;
      ms_q        <= '0;
      retry_q     <= '0;
      fault_q     <= 1'b0;
      samp_ok_q   <= 1'b0;
      samp_temp_q <= '0;
      pend_q      <= 1'b0;
      pend_raw_q  <= '0;
      temp_raw_q  <= '0;
      temp_int_q  <= '0;
      temp_deci_q <= '0;
      alarm_q     <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      presc_q     <= tick ? '0 : presc_q + PW'(1);
      ms_q        <= ms_d;
      retry_q     <= retry_d;
      fault_q     <= fault_d;
      samp_ok_q   <= samp_ok_d;
      samp_temp_q <= samp_temp_d;
      pend_q      <= pend_d;
      pend_raw_q  <= pend_raw_d;
      valid_q     <= pend_q;
      if (pend_q) begin
        temp_raw_q  <= pend_raw_q;
        temp_int_q  <= pend_raw_q[11:4];
        temp_deci_q <= deci_w;
        alarm_q     <= alarm_d;
      end
    end
  end

  assign conv_start = (state_q == S_REQ);
  assign busy       = (state_q != S_IDLE) && (state_q != S_FAULT);
  assign fault      = fault_q;
  assign temp_raw   = temp_raw_q;
  assign temp_int   = temp_int_q;
  assign temp_deci  = temp_deci_q;
  assign temp_valid = valid_q;
  assign alarm      = alarm_q;

endmodule
`default_nettype wire

// File: tb/tb_temp_sample_sched.sv
`default_nettype none
// tb_temp_sample_sched: randomized scoreboard bench for temp_sample_sched,
// with a reference model that also covers the TEMP_AVG_EN build.
module tb_temp_sample_sched;

  localparam int CLK_FREQ_HZ = 1000;
  localparam int PERIOD_MS   = 10;
  localparam int TIMEOUT_MS  = 5;
  localparam int MAX_RETRY   = 3;
  localparam int HYST        = 1;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        force_req = 1'b0;
  logic        sensor_done = 1'b0;
  logic        sensor_ok = 1'b0;
  logic [15:0] sensor_temp = '0;
  logic [7:0]  alarm_th = 8'd30;
  logic        conv_start;
  logic [15:0] temp_raw;
  logic [7:0]  temp_int;
  logic [3:0]  temp_deci;
  logic        temp_valid;
  logic        alarm;
  logic        fault;
  logic        busy;

  temp_sample_sched #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .PERIOD_MS  (PERIOD_MS),
    .TIMEOUT_MS (TIMEOUT_MS),
    .MAX_RETRY  (MAX_RETRY),
    .HYST       (HYST)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .enable     (enable),
    .force_req  (force_req),
    .conv_start (conv_start),
    .sensor_done(sensor_done),
    .sensor_ok  (sensor_ok),
    .sensor_temp(sensor_temp),
    .alarm_th   (alarm_th),
    .temp_raw   (temp_raw),
    .temp_int   (temp_int),
    .temp_deci  (temp_deci),
    .temp_valid (temp_valid),
    .alarm      (alarm),
    .fault      (fault),
    .busy       (busy)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] raw;
    logic [7:0]  ti;
    logic [3:0]  deci;
    logic        al;
    int          at_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  bit   exp_alarm = 1'b0;
  logic prev_conv = 1'b0;
`ifdef TEMP_AVG_EN
  logic [15:0] hist[$];
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: what a successful reading should publish, from the arithmetic rules.
  task automatic model_publish(input logic [15:0] sample, input int due);
    exp_t e;
    int   v, ti, frac, th;
    logic [15:0] r;
`ifdef TEMP_AVG_EN
    int   sum;
    if (hist.size() == 0) begin
      repeat (4) hist.push_front(sample);
    end else begin
      hist.push_front(sample);
      void'(hist.pop_back());
    end
    sum = 0;
    foreach (hist[i]) sum += int'($signed(hist[i]));
    r = 16'(sum >>> 2);
`else
    r = sample;
`endif
    v    = int'($signed(r));
    ti   = (v >= 0) ? v / 16 : -((-v + 15) / 16);
    frac = v - ti * 16;
    th   = int'($signed(alarm_th));
    if (ti >= th) exp_alarm = 1'b1;
    else if (ti < th - HYST) exp_alarm = 1'b0;
    e.raw    = r;
    e.ti     = 8'(ti);
    e.deci   = 4'(frac * 10 / 16);
    e.al     = exp_alarm;
    e.at_cyc = due;
    sb.push_back(e);
  endtask

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      prev_conv = 1'b0;
    end else begin
      if (conv_start) check("conv_back_to_back", 32'(prev_conv), 32'd0);
      prev_conv = conv_start;
      if (temp_valid) begin
        check("publish_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check("temp_raw", 32'(temp_raw), 32'(mon_e.raw));
          check("temp_int", 32'(temp_int), 32'(mon_e.ti));
          check("temp_deci", 32'(temp_deci), 32'(mon_e.deci));
          check("alarm", 32'(alarm), 32'(mon_e.al));
          check("publish_latency", 32'(cyc), 32'(mon_e.at_cyc));
        end
      end
    end
  end

  function automatic logic [15:0] rand_temp();
    int c;
    c = int'($urandom_range(0, 80 * 16)) - 20 * 16;
    return 16'(c);
  endfunction

  task automatic pulse_force();
    force_req = 1'b1;
    @(negedge sys_clk);
    force_req = 1'b0;
  endtask

  task automatic wait_conv(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (conv_start) begin
        at = cyc;
        break;
      end
      @(negedge sys_clk);
    end
    check("conv_start_seen", 32'(at >= 0), 32'd1);
  endtask

  // sensor_done is sampled at edge cyc+1; the publish is visible after edge cyc+3.
  task automatic respond(input bit ok, input logic [15:0] t, input int delay);
    repeat (delay) @(negedge sys_clk);
    sensor_done = 1'b1;
    sensor_ok   = ok;
    sensor_temp = t;
    if (ok) model_publish(t, cyc + 3);
    @(negedge sys_clk);
    sensor_done = 1'b0;
    sensor_ok   = 1'b0;
    sensor_temp = 16'($urandom);
  endtask

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    check("drain_in_budget", 32'(n < budget), 32'd1);
  endtask

  task automatic sample_once(input logic [15:0] raw, input int delay);
    pulse_force();
    check("force_to_conv", 32'(conv_start), 32'd1);
    respond(1'b1, raw, delay);
    wait_quiet(50);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, n, at;
    logic [15:0] raw;
    logic [15:0] seq_in [4];
    logic [15:0] seq_exp [4];

    seq_in[0] = 16'h0100; seq_in[1] = 16'h0200; seq_in[2] = 16'h0200; seq_in[3] = 16'h0200;
`ifdef TEMP_AVG_EN
    seq_exp[0] = 16'h0100; seq_exp[1] = 16'h0140; seq_exp[2] = 16'h0180; seq_exp[3] = 16'h01C0;
`else
    seq_exp[0] = 16'h0100; seq_exp[1] = 16'h0200; seq_exp[2] = 16'h0200; seq_exp[3] = 16'h0200;
`endif

    // Reset state
    repeat (3) @(negedge sys_clk);
    check("rst_conv_start", 32'(conv_start), 32'd0);
    check("rst_temp_valid", 32'(temp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_alarm", 32'(alarm), 32'd0);
    check("rst_temp_raw", 32'(temp_raw), 32'd0);
    check("rst_temp_int", 32'(temp_int), 32'd0);
    check("rst_temp_deci", 32'(temp_deci), 32'd0);
    sys_rst_n = 1'b1;

    // Periodic sampling
    alarm_th = 8'd30;
    enable   = 1'b1;
    wait_conv(40, t0);
    respond(1'b1, 16'h0191, 3);
    wait_conv(40, t1);
    check("periodic_spacing", 32'(t1 - t0), 32'(1 + 3 + 1 + PERIOD_MS));
    respond(1'b1, rand_temp(), 3);
    wait_conv(40, t2);
    check("periodic_spacing", 32'(t2 - t1), 32'(1 + 3 + 1 + PERIOD_MS));
    respond(1'b1, rand_temp(), 3);
    enable = 1'b0;
    wait_quiet(50);

    // Negative value
    sample_once(16'hFFF8, 2);
    check("neg_temp_int", 32'(temp_int), 32'h0000_00FF);
    check("neg_temp_deci", 32'(temp_deci), 32'd5);

    // Alarm hysteresis: 30.0, 29.0, 28.875 degC against threshold 30
    sample_once(16'h01E0, 2);
    check("hyst_set", 32'(alarm), 32'd1);
    sample_once(16'h01D0, 2);
    check("hyst_hold", 32'(alarm), 32'd1);
    sample_once(16'h01CE, 2);
    check("hyst_clear", 32'(alarm), 32'd0);

    // Randomized samples, some with a failed first attempt
    for (int k = 0; k < 10; k++) begin
      alarm_th = 8'($urandom_range(20, 40));
      raw = rand_temp();
      pulse_force();
      check("force_to_conv", 32'(conv_start), 32'd1);
      if ($urandom_range(0, 2) == 0) begin
        respond(1'b0, 16'($urandom), int'($urandom_range(1, 4)));
        wait_conv(20, at);
      end
      respond(1'b1, raw, int'($urandom_range(1, 5)));
      wait_quiet(60);
    end

    // Timeout, retries, fault
    enable = 1'b1;
    pulse_force();
    wait_conv(1, t0);
    @(negedge sys_clk);
    wait_conv(20, t1);
    check("retry_spacing", 32'(t1 - t0), 32'(TIMEOUT_MS + 2));
    @(negedge sys_clk);
    wait_conv(20, t2);
    check("retry_spacing", 32'(t2 - t1), 32'(TIMEOUT_MS + 2));
    repeat (TIMEOUT_MS + 2) @(negedge sys_clk);
    check("fault_set", 32'(fault), 32'd1);
    check("fault_not_busy", 32'(busy), 32'd0);
    n = 0;
    repeat (30) begin
      @(negedge sys_clk);
      if (conv_start) n++;
    end
    check("no_conv_in_fault", 32'(n), 32'd0);
    check("fault_held", 32'(fault), 32'd1);
    pulse_force();
    check("fault_force_conv", 32'(conv_start), 32'd1);
    check("fault_cleared", 32'(fault), 32'd0);
    respond(1'b1, rand_temp(), 2);
    enable = 1'b0;
    wait_quiet(50);

    // Completion on the timeout tick, force_req ignored during WAIT
    pulse_force();
    wait_conv(1, t0);
    repeat (2) @(negedge sys_clk);
    force_req = 1'b1;
    @(negedge sys_clk);
    force_req = 1'b0;
    respond(1'b1, 16'h0235, 2);
    n = 0;
    repeat (25) begin
      @(negedge sys_clk);
      if (conv_start) n++;
    end
    check("no_extra_conv", 32'(n), 32'd0);
    check("collision_published", 32'(temp_raw != 16'h0000), 32'd1);

    // Reset in the middle of WAIT
    pulse_force();
    wait_conv(1, t0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_conv_start", 32'(conv_start), 32'd0);
    check("arst_temp_raw", 32'(temp_raw), 32'd0);
    check("arst_temp_int", 32'(temp_int), 32'd0);
    check("arst_temp_deci", 32'(temp_deci), 32'd0);
    check("arst_alarm", 32'(alarm), 32'd0);
    check("arst_fault", 32'(fault), 32'd0);
    exp_alarm = 1'b0;
`ifdef TEMP_AVG_EN
    hist.delete();
`endif
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    sensor_done = 1'b1;
    sensor_ok   = 1'b1;
    sensor_temp = 16'h0321;
    @(negedge sys_clk);
    sensor_done = 1'b0;
    sensor_ok   = 1'b0;
    repeat (5) @(negedge sys_clk);
    check("stray_done_busy", 32'(busy), 32'd0);
    check("stray_done_raw", 32'(temp_raw), 32'd0);

    // History sequence from a fresh reset
    for (int k = 0; k < 4; k++) begin
      sample_once(seq_in[k], 2);
      check("seq_temp_raw", 32'(temp_raw), 32'(seq_exp[k]));
    end

    repeat (5) @(negedge sys_clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/temp_sample_sched.md
# temp_sample_sched

Periodic sampling scheduler for the DS18B20 1-Wire temperature path. It issues conversion requests to the 1-Wire sensor driver over a start/done handshake, with period, timeout and retry control. It converts the returned 16-bit raw reading into signed integer and tenths fields and raises an over-temperature alarm with hysteresis. It sits between the sensor driver and the health-monitor display/alarm logic.

## Interface
- `CLK_FREQ_HZ`, 50_000_000, system clock frequency; the 1 ms tick period is CLK_FREQ_HZ/1000 cycles.
- `PERIOD_MS`, 1000, idle gap between samples, in ms ticks.
- `TIMEOUT_MS`, 1500, maximum wait for `sensor_done` after `conv_start`.
- `MAX_RETRY`, 3, consecutive failed attempts before `fault`.
- `HYST`, 1, alarm release hysteresis in °C.
- `sys_clk` in 1: single clock, rising edge.
- `sys_rst_n` in 1: reset, asynchronous and active-low.
- `enable` in 1: level; enables periodic sampling.
- `force_req` in 1: one-cycle pulse; requests an immediate sample.
- `conv_start` out 1: one-cycle pulse to the sensor driver.
- `sensor_done` in 1: one-cycle pulse from the driver; `sensor_ok`/`sensor_temp` are valid in this same cycle.
- `sensor_ok` in 1: presence pulse detected and read completed.
- `sensor_temp` in 16: raw DS18B20 reading, two's complement, 1/16 °C LSB.
- `alarm_th` in 8: signed alarm threshold, °C.
- `temp_raw` out 16: last published raw value (averaged if enabled).
- `temp_int` out 8: signed floor(temp_raw/16).
- `temp_deci` out 4: (temp_raw[3:0]*10)>>4, range 0..9; value = temp_int + temp_deci/10.
- `temp_valid` out 1: one-cycle pulse on each publish.
- `alarm` out 1: over-temperature flag.
- `fault` out 1: retry budget exhausted.
- `busy` out 1: high in every state except IDLE and FAULT.

## Operation
- **Reset values:** all outputs 0; state IDLE; all counters 0.
- **1 ms prescaler** runs free. `tick` is one cycle every CLK_FREQ_HZ/1000 cycles.
- **IDLE:** the ms counter clears on entry and counts ticks.
  - If `enable` is high and the counter reaches PERIOD_MS-1 on a tick, go to REQ.
  - If `force_req` is high, go to REQ regardless of `enable` or the counter.
- **REQ:** `conv_start`=1 for this cycle only. Clear the ms counter, go to WAIT.
- **WAIT:** `sensor_done`=1 latches `sensor_ok` and `sensor_temp`, then go to EVAL.
  - If the counter reaches TIMEOUT_MS-1 on a tick, this is a failed attempt.
  - `sensor_done` beats a timeout in the same cycle.
  - `force_req` is ignored here.
- **EVAL, success (`sensor_ok`=1):**
  - Publish `temp_raw`, `temp_int`, `temp_deci`; pulse `temp_valid`.
  - Update `alarm`; clear the retry count and `fault`.
  - Go to IDLE.
- **Failed attempt (EVAL with `sensor_ok`=0, or timeout):** retry count +1.
  - If count == MAX_RETRY: set `fault`, go to FAULT.
  - Otherwise wait one tick (GAP state), then REQ.
  - Outputs hold their last published values.
- **FAULT:**
  - `force_req` clears `fault` and the retry count, then go to REQ.
  - `enable`=0 clears `fault` and the retry count, then go to IDLE.
  - `conv_start` is never issued.
- **`enable` deassert** acts only in IDLE/FAULT. An in-flight attempt completes and publishes normally.
- **Alarm** is evaluated only on a publish, using signed compare.
  - Set when `temp_int` >= `alarm_th`.
  - Clear when `temp_int` < `alarm_th` - HYST.
  - Otherwise hold.
- **Arithmetic:** `temp_int` = `temp_raw`[11:4], an arithmetic floor. Example: raw 0xFFF8 (-0.5 °C) gives `temp_int`=-1 (0xFF), `temp_deci`=5.

## Timing
- `conv_start` is asserted 1 cycle after the REQ decision edge. A `force_req` sampled in IDLE at edge k gives `conv_start` high during cycle k+1.
- `sensor_done` sampled at edge k gives EVAL at k+1. Outputs update and `temp_valid` is high in the cycle following edge k+2.
- Publish latency is 2 cycles, in both configurations.
- Reset asserted mid-attempt returns to IDLE asynchronously. A `sensor_done` arriving after reset release while in IDLE is ignored.
- `conv_start` is never high in two consecutive cycles.
- Only one attempt is outstanding at a time.

## Configuration
- **`TEMP_AVG_EN` defined:**
  - A 4-entry history of successful raw samples feeds the output.
  - `temp_raw` = arithmetic (sum of 4)>>>2, using an 18-bit signed sum.
  - The first successful sample after reset preloads all 4 entries.
  - Failed attempts do not touch the history.
- **`TEMP_AVG_EN` undefined:** `temp_raw` is the latest successful `sensor_temp`. No history storage.

## Test plan
Settings for all scenarios: CLK_FREQ_HZ=1000 (tick every cycle), PERIOD_MS=10, TIMEOUT_MS=5, MAX_RETRY=3.
- **Periodic sample:** `enable`=1, driver answers with ok and 0x0191 at 3 cycles after `conv_start`. Expect `conv_start` every 10 ticks plus handshake, `temp_int`=25, `temp_deci`=0, `temp_valid` 2 cycles after `sensor_done`.
- **Negative value:** `force_req` with raw 0xFFF8. Expect `temp_int`=0xFF, `temp_deci`=5, `alarm`=0 with `alarm_th`=30.
- **Timeout/retry to fault:** no `sensor_done`. Expect 3 `conv_start` pulses spaced 5+1 ticks, then `fault`=1 and no further `conv_start`. Then `force_req` clears `fault` and issues `conv_start`.
- **Alarm hysteresis:** `alarm_th`=30, raw sequence 30.0, 29.0, 28.9 °C. Expect `alarm` 1, 1, 0.
- **Collision and reset:** `sensor_done` with ok on the timeout tick, and `force_req` during WAIT. Expect publish, no extra `conv_start`. Then `sys_rst_n` low mid-WAIT: all outputs 0 immediately.
- **`TEMP_AVG_EN` only:** samples 0x0100, 0x0200, 0x0200, 0x0200 °C raw. Expect `temp_raw` 0x0100, 0x0140, 0x0180, 0x01C0.
